serial_addsub: RTL and testbench

Parametrised bit-serial two's-complement adder/subtractor. It is the sequential successor to the ripple complement-adder chain.
- One full-adder slice plus a carry flip-flop processes one bit per clock, LSB first, across W cycles.
- It returns a (W+1)-bit sign-correct result plus carry and overflow flags.
- It sits between operand producers and consumers in the datapath, with valid/ready handshakes on both sides.

---
 rtl/serial_addsub.sv | 138 +++++++++++++
 tb/tb_serial_addsub.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice plus a carry flop,
// LSB first over W cycles, returning a sign-extended (W+1)-bit result with carry and overflow flags.
module serial_addsub #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   res,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  sa_q, sa_d;
    logic [W-1:0]  sb_q, sb_d;
    logic [W-1:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          a_sign_q, a_sign_d;
    logic          b_sign_q, b_sign_d;
    logic [W:0]    res_q, res_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          out_valid_q, out_valid_d;

    logic sum_bit;
    logic carry_nxt;
    logic res_msb;

    assign sum_bit   = sa_q[0] ^ sb_q[0] ^ carry_q;
    assign carry_nxt = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
    // Sign of the exact (W+1)-bit sum: sign-extend both operands, add the final carry.
    assign res_msb   = a_sign_q ^ b_sign_q ^ carry_nxt;

    always_comb begin
        state_d     = state_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_sign_d    = a_sign_q;
        b_sign_d    = b_sign_q;
        res_d       = res_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sa_d     = a;
                    sb_d     = op ? ~b : b;
                    carry_d  = op;
                    a_sign_d = a[W-1];
                    b_sign_d = op ? ~b[W-1] : b[W-1];
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                sr_d    = {sum_bit, sr_q[W-1:1]};
                carry_d = carry_nxt;
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    cout_d      = carry_nxt;
                    res_d       = {res_msb, sum_bit, sr_q[W-1:1]};
                    ovf_d       = res_msb ^ sum_bit;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sa_q        <= '0;
            sb_q        <= '0;
            sr_q        <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_sign_q    <= 1'b0;
            b_sign_q    <= 1'b0;
            res_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_sign_q    <= a_sign_d;
            b_sign_q    <= b_sign_d;
            res_q       <= res_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed cases plus randomized transactions
// compared against a plain-arithmetic signed reference model.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   res;
    logic         cout;
    logic         ovf;

    int total;
    int bad;

    serial_addsub #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, count RUN edges, optional backpressure, output handshake.
    task automatic applyStimulus(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                                 input logic op_in, input int hold, input bit noise);
        int          sa, sb, exact, ua, ub, lat;
        logic [31:0] ex_bits;
        logic [W:0]  exp_res;
        logic        exp_cout, exp_ovf;

        sa      = int'($signed(a_in));
        sb      = int'($signed(b_in));
        ua      = int'(a_in);
        ub      = int'(b_in);
        exact   = op_in ? (sa - sb) : (sa + sb);
        ex_bits = exact;
        exp_res = ex_bits[W:0];
        exp_ovf = (exact > (2 ** (W - 1)) - 1) || (exact < -(2 ** (W - 1)));
        exp_cout = op_in ? (ua >= ub) : ((ua + ub) >= (2 ** W));

        checkOutput("in_ready_idle", {31'b0, in_ready}, 32'd1);
        out_ready = (hold == 0);
        a         = a_in;
        b         = b_in;
        op        = op_in;
        in_valid  = 1'b1;
        stepClock();
        in_valid = 1'b0;

        lat = 0;
        while (!out_valid && lat < 4 * W) begin
            checkOutput("in_ready_run", {31'b0, in_ready}, 32'd0);
            if (noise) begin
                a        = W'($urandom);
                b        = W'($urandom);
                op       = 1'($urandom);
                in_valid = 1'($urandom);
            end
            stepClock();
            lat++;
        end
        in_valid = 1'b0;

        checkOutput("latency", lat, W);
        checkOutput("res", {{(31 - W){1'b0}}, res}, {{(31 - W){1'b0}}, exp_res});
        checkOutput("cout", {31'b0, cout}, {31'b0, exp_cout});
        checkOutput("ovf", {31'b0, ovf}, {31'b0, exp_ovf});

        for (int i = 0; i < hold; i++) begin
            stepClock();
            checkOutput("bp_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
            checkOutput("bp_res", {{(31 - W){1'b0}}, res}, {{(31 - W){1'b0}}, exp_res});
            checkOutput("bp_cout", {31'b0, cout}, {31'b0, exp_cout});
            checkOutput("bp_ovf", {31'b0, ovf}, {31'b0, exp_ovf});
        end
        out_ready = 1'b1;
        stepClock();
        checkOutput("hs_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("hs_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = 1'b0;
        out_ready = 1'b1;

        stepClock();
        stepClock();
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_res", {{(31 - W){1'b0}}, res}, 32'd0);
        checkOutput("rst_cout", {31'b0, cout}, 32'd0);
        checkOutput("rst_ovf", {31'b0, ovf}, 32'd0);
        rst_n = 1'b1;
        stepClock();

        applyStimulus(8'd100, 8'd27, 1'b0, 0, 1'b0);
        applyStimulus(8'd100, 8'd28, 1'b0, 0, 1'b0);
        applyStimulus(8'd5, 8'd7, 1'b1, 0, 1'b0);
        applyStimulus(8'h80, 8'd1, 1'b1, 0, 1'b0);
        applyStimulus(8'd3, 8'h80, 1'b1, 0, 1'b0);
        applyStimulus(8'h7F, 8'd1, 1'b0, 5, 1'b0);
        applyStimulus(8'h81, 8'h7F, 1'b1, 0, 1'b1);

        // Abort an operation partway through RUN.
        a        = 8'd42;
        b        = 8'd17;
        op       = 1'b0;
        in_valid = 1'b1;
        stepClock();
        in_valid = 1'b0;
        repeat (3) stepClock();
        rst_n = 1'b0;
        stepClock();
        checkOutput("abort_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("abort_res", {{(31 - W){1'b0}}, res}, 32'd0);
        checkOutput("abort_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        stepClock();
        checkOutput("abort_no_result", {31'b0, out_valid}, 32'd0);
        applyStimulus(8'hFF, 8'hFF, 1'b0, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom),
                          int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
